// File: rtl/reset_sequencer.sv
// reset_sequencer
// Releases downstream resets in a fixed order once the incoming reset drops.
// While the incoming reset is high, every downstream reset is held. After it
// falls, all downstream resets stay high for a settle period. Stages are then
// released one at a time, and each stage must report init-done before the next
// one is released. If a stage does not acknowledge in time, the sequencer stops
// and flags which stage failed.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   init_done  per-stage init-complete level; only the current stage's bit is looked at
//   restart    one-cycle request to rerun the sequence; honoured only in READY or ERROR
//   rst_out    per-stage downstream reset, active-high, registered
//   ready      all stages released and acknowledged
//   err        sticky timeout flag
//   err_stage  index of the stage that timed out
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_HOLD     | all rst_out high, settle timer running
// S_WAIT_ACK | rst_out[stage] released, waiting for init_done[stage]
// S_GAP      | stage acknowledged, spacing timer before releasing stage+1
// S_READY    | every stage released and acknowledged
// S_ERROR    | a stage timed out; released stages stay released
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 16,
    localparam int ST_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] init_done,
    input  logic                  restart,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  err,
    output logic [ST_W-1:0]       err_stage
);

    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_HG > TIMEOUT) ? MAX_HG : TIMEOUT;
    localparam int TW      = $clog2(MAX_ALL) + 1;

    localparam logic [TW-1:0]   HOLD_LAST  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]   GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]   TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [ST_W-1:0] LAST_STAGE = ST_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_ACK,
        S_GAP,
        S_READY,
        S_ERROR
    } state_t;

    state_t                 state, state_nxt;
    logic [TW-1:0]          timer, timer_nxt;
    logic [ST_W-1:0]        stage, stage_nxt;
    logic [NUM_STAGES-1:0]  rst_out_nxt;
    logic                   ready_nxt;
    logic                   err_nxt;
    logic [ST_W-1:0]        err_stage_nxt;
    logic [ST_W-1:0]        stage_inc;
    logic                   ack;

    assign stage_inc = stage + 1'b1;
    assign ack       = init_done[stage];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HOLD;
            timer     <= '0;
            stage     <= '0;
            rst_out   <= '1;
            ready     <= 1'b0;
            err       <= 1'b0;
            err_stage <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            stage     <= stage_nxt;
            rst_out   <= rst_out_nxt;
            ready     <= ready_nxt;
            err       <= err_nxt;
            err_stage <= err_stage_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        stage_nxt     = stage;
        rst_out_nxt   = rst_out;
        ready_nxt     = ready;
        err_nxt       = err;
        err_stage_nxt = err_stage;

        case (state)
            S_HOLD: begin
                if (timer == HOLD_LAST) begin
                    state_nxt   = S_WAIT_ACK;
                    timer_nxt   = '0;
                    rst_out_nxt = rst_out & ~NUM_STAGES'(1);
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            S_WAIT_ACK: begin
                // An ack on the timeout cycle still counts.
                if (ack && stage == LAST_STAGE) begin
                    state_nxt = S_READY;
                    ready_nxt = 1'b1;
                end else if (ack) begin
                    state_nxt = S_GAP;
                    timer_nxt = '0;
                end else if (timer == TO_LAST) begin
                    state_nxt     = S_ERROR;
                    err_nxt       = 1'b1;
                    err_stage_nxt = stage;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            S_GAP: begin
                if (timer == GAP_LAST) begin
                    state_nxt   = S_WAIT_ACK;
                    timer_nxt   = '0;
                    stage_nxt   = stage_inc;
                    rst_out_nxt = rst_out & ~(NUM_STAGES'(1) << stage_inc);
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            S_READY, S_ERROR: begin
                if (restart) begin
                    state_nxt     = S_HOLD;
                    timer_nxt     = '0;
                    stage_nxt     = '0;
                    rst_out_nxt   = '1;
                    ready_nxt     = 1'b0;
                    err_nxt       = 1'b0;
                    err_stage_nxt = '0;
                end
            end

            default: begin
                state_nxt   = S_HOLD;
                timer_nxt   = '0;
                stage_nxt   = '0;
                rst_out_nxt = '1;
                ready_nxt   = 1'b0;
                err_nxt     = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the single testbench/system clock and synchronous reset and turns them into an ordered, handshaked reset release for downstream blocks in the multadd datapath. After the incoming reset falls, it holds every downstream reset for a fixed settle period, then releases one stage at a time. Each stage must report init-done before the next is released. It reports `ready` when all stages are up, and `err` with the failing stage index if any stage times out.

## Interface
- `NUM_STAGES`, 3: number of sequenced downstream resets (legal range ≥1).
- `HOLD_CYCLES`, 4: cycles all outputs stay in reset after `rst` is sampled low (≥1).
- `GAP_CYCLES`, 2: cycles between stage i acknowledging and stage i+1 being released (≥1).
- `TIMEOUT`, 16: cycles a released stage has to raise its `init_done` (≥1).

- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `init_done`  input  NUM_STAGES  per-stage init-complete level from downstream block i.
- `restart`  input  1  single-cycle request to rerun the sequence; honoured only in READY or ERROR.
- `rst_out`  output  NUM_STAGES  per-stage downstream reset, active-high, registered.
- `ready`  output  1  all stages released and acknowledged.
- `err`  output  1  sticky timeout flag.
- `err_stage`  output  max(1,$clog2(NUM_STAGES))  index of the stage that timed out.

## Operation
- The FSM has 5 states:
  - HOLD: every `rst_out` bit is high. `timer` counts up.
  - WAIT_ACK: `rst_out[stage]` is low. Waits for `init_done[stage]`.
  - GAP: timer runs before the next stage is released.
  - READY
  - ERROR
- A single `timer` counter is shared by the states. Its width is `$clog2` of the largest of HOLD_CYCLES, GAP_CYCLES and TIMEOUT, plus 1. A `stage` index register tracks the current stage.
- Reset (`rst` sampled high): state goes to HOLD, `timer`=0, `stage`=0.
  - Outputs: `rst_out` = all ones, `ready`=0, `err`=0, `err_stage`=0.
  - These apply from any state, including mid-sequence.
- HOLD:
  - If `timer`==HOLD_CYCLES-1: go to WAIT_ACK, clear `rst_out[0]`, `timer`=0.
  - Otherwise: `timer`++.
- WAIT_ACK:
  - If `init_done[stage]`=1 and `stage`==NUM_STAGES-1: go to READY and set `ready`=1.
  - If `init_done[stage]`=1 and `stage` is not the last: go to GAP, `timer`=0.
  - Else if `timer`==TIMEOUT-1: go to ERROR, set `err`=1, `err_stage`=`stage`.
  - Else: `timer`++.
  - If ack and timeout occur in the same cycle, the ack wins.
- GAP:
  - If `timer`==GAP_CYCLES-1: `stage`++, clear `rst_out[stage+1]`, go to WAIT_ACK, `timer`=0.
  - Otherwise: `timer`++.
- READY: holds. Released stages stay out of reset. `init_done` is ignored.
- ERROR: holds.
  - Stages already released stay low, including the failing stage.
  - Unreleased stages stay high. `ready` stays 0.
- `restart` in READY or ERROR:
  - Next edge: `rst_out` = all ones, `ready`=0, `err`=0, `err_stage`=0, `stage`=0, `timer`=0, state HOLD.
  - `restart` in HOLD, WAIT_ACK or GAP is ignored.
  - If `rst` and `restart` are both high, `rst` wins. The result is the same.
- `init_done` bits of stages other than the current `stage` are ignored at all times.
- A `rst_out` bit, once cleared, never reasserts except through `rst` or `restart`. Bits are released strictly in index order.

## Timing
- Edge numbering: edge 1 is the first rising edge at which `rst` is sampled low.
- `rst_out[0]` falls after edge HOLD_CYCLES (edge 4 by default).
- Stage i acknowledged at edge A: `rst_out[i+1]` falls after edge A+GAP_CYCLES.
- Stage released at edge R with no ack: `err` rises after edge R+TIMEOUT.
  - An ack sampled at edge R+TIMEOUT still succeeds.
- Last-stage ack sampled at edge A: `ready`=1 after edge A. Latency from input to output is one registered cycle.
- All outputs come directly from flops. There is no combinational path from any input to any output.
- `restart` is acted on at the edge where it is sampled. The outputs change after that edge.

## Test plan
- Defaults, nominal sequence: `rst`=1 for 3 edges then 0. Tie `init_done[i]` high 2 cycles after `rst_out[i]` falls.
  - `rst_out[0]` low after edge 4.
  - `rst_out[1]` low after edge 8.
  - `rst_out[2]` low after edge 12.
  - `ready`=1 after edge 14.
  - `err`=0 throughout.
- Timeout: `init_done[1]` held 0, other stages ack 2 cycles after release.
  - `rst_out[1]` falls after edge 8.
  - `err`=1 and `err_stage`=1 after edge 24.
  - `rst_out[2]` stays 1. `ready` stays 0.
- Boundary ack: `init_done[0]` rises exactly at edge 20 (timer=15).
  - No error.
  - `rst_out[1]` low after edge 22.
- Reset mid-sequence: assert `rst` during GAP after stage 0's ack.
  - Next edge: `rst_out`=3'b111, `ready`=0.
  - On release, the full sequence repeats with the same edge offsets.
- Restart: pulse `restart` in READY.
  - `rst_out`=3'b111 and `ready`=0 after that edge, then the nominal sequence repeats.
  - Pulse `restart` in WAIT_ACK: it is ignored.
  - Pulse `restart` in ERROR: `err` clears.
- Stray acks: raise `init_done[2]` during HOLD and during stage-0 WAIT_ACK.
  - No effect on sequencing.
  - `rst_out[2]` remains 1 until its GAP completes.
